// File: rtl/switch_event_arbiter.sv
// switch_event_arbiter
//   Turns edges on NUM_SW debounced switch lines into a single valid/ready
//   event stream. Each switch owns one pending slot. Slots are served
//   round-robin through a registered output stage. Sticky per-switch overflow
//   flags record events dropped because the slot was still occupied.
//   Optional feature macro: SWITCH_RELEASE_EVENTS_EN (release edges also
//   produce events, with o_Event_Press = 0).
module switch_event_arbiter #(
  parameter int NUM_SW = 4,
  parameter int ID_W   = 2
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic              o_Event_Valid,
  input  logic              i_Event_Ready,
  output logic [ID_W-1:0]   o_Event_Id,
  output logic              o_Event_Press,
  output logic [NUM_SW-1:0] o_Overflow,
  input  logic              i_Overflow_Clear
);

  localparam int IDX_W = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;

  typedef enum logic {ST_IDLE, ST_OFFER} state_t;

  state_t            state_reg, state_next;
  logic [NUM_SW-1:0] switch_prev_reg;
  logic              armed_reg;
  logic [NUM_SW-1:0] pend_reg;
  logic [NUM_SW-1:0] kind_reg;
  logic [NUM_SW-1:0] overflow_reg;
  logic [ID_W-1:0]   last_grant_reg;
  logic [ID_W-1:0]   event_id_reg;
  logic              event_press_reg;

  logic [NUM_SW-1:0] edge_vec;
  logic [NUM_SW-1:0] edge_kind;
  logic [NUM_SW-1:0] win_onehot;
  logic [NUM_SW-1:0] ovf_set;
  logic [IDX_W-1:0]  win_idx;
  logic              any_pend;
  logic              load;

  // Edge detection is suppressed until the arm cycle has captured a valid
  // previous level, so switches held through reset produce nothing.
`ifdef SWITCH_RELEASE_EVENTS_EN
  assign edge_vec  = armed_reg ? (i_Switch ^ switch_prev_reg) : '0;
  assign edge_kind = i_Switch;
`else
  assign edge_vec  = armed_reg ? (i_Switch & ~switch_prev_reg) : '0;
  assign edge_kind = '1;
`endif

  assign any_pend = |pend_reg;

  // Previous-level register and arm flag.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      switch_prev_reg <= '0;
      armed_reg       <= 1'b0;
    end else begin
      switch_prev_reg <= i_Switch;
      armed_reg       <= 1'b1;
    end
  end

  // Round-robin pick: scanning offsets from high to low lets the smallest
  // offset after the last grant win without an early exit.
  always_comb begin
    int cand;
    win_idx = '0;
    cand    = 0;
    for (int off = NUM_SW; off >= 1; off--) begin
      cand = (int'(last_grant_reg) + off) % NUM_SW;
      if (pend_reg[IDX_W'(cand)]) begin
        win_idx = IDX_W'(cand);
      end
    end
  end

  // Output FSM state register.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and load decision: a slot is loaded whenever the output stage
  // is empty or is being emptied by a handshake this cycle.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (any_pend) begin
          load       = 1'b1;
          state_next = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (i_Event_Ready) begin
          if (any_pend) begin
            load = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_slot
      assign win_onehot[gi] = load && (win_idx == IDX_W'(gi));
      // A new edge is dropped only if the slot stays occupied this cycle.
      assign ovf_set[gi]    = edge_vec[gi] & pend_reg[gi] & ~win_onehot[gi];

      // Per-switch pending slot; a same-cycle load frees room for the edge.
      always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
          pend_reg[gi] <= 1'b0;
          kind_reg[gi] <= 1'b0;
        end else if (edge_vec[gi] && !ovf_set[gi]) begin
          pend_reg[gi] <= 1'b1;
          kind_reg[gi] <= edge_kind[gi];
        end else if (win_onehot[gi]) begin
          pend_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Sticky overflow flags; a new drop wins over a simultaneous clear.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      overflow_reg <= '0;
    end else begin
      overflow_reg <= (overflow_reg & ~{NUM_SW{i_Overflow_Clear}}) | ovf_set;
    end
  end

  // Registered output stage and round-robin pointer.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      event_id_reg    <= '0;
      event_press_reg <= 1'b0;
      last_grant_reg  <= ID_W'(NUM_SW - 1);
    end else if (load) begin
      event_id_reg    <= ID_W'(win_idx);
      event_press_reg <= kind_reg[win_idx];
      last_grant_reg  <= ID_W'(win_idx);
    end
  end

  assign o_Event_Valid = (state_reg == ST_OFFER);
  assign o_Event_Id    = event_id_reg;
  assign o_Event_Press = event_press_reg;
  assign o_Overflow    = overflow_reg;

endmodule

// File: tb/tb_switch_event_arbiter.sv
// Testbench for switch_event_arbiter: directed vector table, reset corner
// sequence, then randomized traffic against a behavioural model.
module tb_switch_event_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
`ifdef SWITCH_RELEASE_EVENTS_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  sw  = '0;
  logic          rdy = 1'b0;
  logic          clr = 1'b0;
  logic          ev_valid;
  logic [IW-1:0] ev_id;
  logic          ev_press;
  logic [N-1:0]  ovf;

  switch_event_arbiter #(.NUM_SW(N), .ID_W(IW)) dut (
    .i_Clk            (clk),
    .i_Reset          (rst),
    .i_Switch         (sw),
    .o_Event_Valid    (ev_valid),
    .i_Event_Ready    (rdy),
    .o_Event_Id       (ev_id),
    .o_Event_Press    (ev_press),
    .o_Overflow       (ovf),
    .i_Overflow_Clear (clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0]  sw;
    logic          rdy;
    logic          clr;
    logic          ev;
    logic [IW-1:0] id;
    logic          pr;
    logic [N-1:0]  ovf;
  } vec_t;

  localparam int NV = 45;
  vec_t tbl [NV];

  // Behavioural model: pending events per switch, served round-robin.
  logic [N-1:0]  m_pend, m_kind, m_prev, m_ovf;
  bit            m_armed, m_offer;
  int            m_last;
  logic [IW-1:0] m_id;
  logic          m_press;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_kind = '0; m_prev = '0; m_ovf = '0;
    m_armed = 1'b0; m_offer = 1'b0; m_last = N - 1;
    m_id = '0; m_press = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] s, input logic r, input logic c);
    int win;
    logic [N-1:0] np, nk, setv;
    bit pr, rl;
    win = -1; np = m_pend; nk = m_kind; setv = '0;
    if (!m_offer || r) begin
      for (int d = 1; d <= N; d++) begin
        if (win < 0 && m_pend[(m_last + d) % N]) win = (m_last + d) % N;
      end
      if (win >= 0) begin
        m_id = IW'(win); m_press = m_kind[win]; np[win] = 1'b0;
        m_last = win; m_offer = 1'b1;
      end else begin
        m_offer = 1'b0;
      end
    end
    if (m_armed) begin
      for (int k = 0; k < N; k++) begin
        pr = s[k] && !m_prev[k];
        rl = REL && !s[k] && m_prev[k];
        if (pr || rl) begin
          if (m_pend[k] && win != k) setv[k] = 1'b1;
          else begin np[k] = 1'b1; nk[k] = pr; end
        end
      end
    end
    m_ovf = (c ? '0 : m_ovf) | setv;
    m_pend = np; m_kind = nk; m_prev = s; m_armed = 1'b1;
  endtask

  // One clock: drive at the falling edge, sample at the next falling edge.
  task automatic cycle(input logic [N-1:0] s, input logic r, input logic c);
    sw = s; rdy = r; clr = c;
    model_step(s, r, c);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cmp_model(input string tag);
    check({tag, " valid"}, 32'(ev_valid), 32'(m_offer));
    check({tag, " id"},    32'(ev_id),    32'(m_id));
    check({tag, " press"}, 32'(ev_press), 32'(m_press));
    check({tag, " ovf"},   32'(ovf),      32'(m_ovf));
  endtask

  task automatic cmp_zero(input string tag);
    check({tag, " valid"}, 32'(ev_valid), 32'd0);
    check({tag, " id"},    32'(ev_id),    32'd0);
    check({tag, " press"}, 32'(ev_press), 32'd0);
    check({tag, " ovf"},   32'(ovf),      32'd0);
  endtask

  task automatic set_row(input int i, input logic [N-1:0] s, input logic r, input logic c,
                         input logic e, input logic [IW-1:0] id, input logic p, input logic [N-1:0] o);
    tbl[i].sw = s; tbl[i].rdy = r; tbl[i].clr = c;
    tbl[i].ev = e; tbl[i].id = id; tbl[i].pr = p; tbl[i].ovf = o;
  endtask

  task automatic fill_table();
    for (int i = 0; i < 10; i++) set_row(i, 4'b0010, 1, 0, 0, 0, 0, 4'h0);
    set_row(10, 4'b0000, 0, 0, 0, 0, 0, 4'h0);
    set_row(11, 4'b1011, 0, 0, 0, 0, 0, 4'h0);
    set_row(12, 4'b1011, 0, 0, 1, 0, 1, 4'h0);
    set_row(13, 4'b1011, 0, 0, 1, 0, 1, 4'h0);
    set_row(14, 4'b1011, 1, 0, 1, 1, 1, 4'h0);
    set_row(15, 4'b1011, 1, 0, 1, 3, 1, 4'h0);
    set_row(16, 4'b1011, 1, 0, 0, 3, 1, 4'h0);
    set_row(17, 4'b1111, 1, 0, 0, 3, 1, 4'h0);
    set_row(18, 4'b1111, 1, 0, 1, 2, 1, 4'h0);
    set_row(19, 4'b1111, 1, 0, 0, 2, 1, 4'h0);
    set_row(20, 4'b0000, 1, 0, 0, 2, 1, 4'h0);
    set_row(21, 4'b0001, 1, 0, 0, 2, 1, 4'h0);
    set_row(22, 4'b0001, 1, 0, 1, 0, 1, 4'h0);
    set_row(23, 4'b0000, 1, 0, 0, 0, 1, 4'h0);
    set_row(24, 4'b0011, 0, 0, 0, 0, 1, 4'h0);
    set_row(25, 4'b0011, 0, 0, 1, 1, 1, 4'h0);
    set_row(26, 4'b0011, 1, 0, 1, 0, 1, 4'h0);
    set_row(27, 4'b0011, 1, 0, 0, 0, 1, 4'h0);
    set_row(28, 4'b0111, 0, 0, 0, 0, 1, 4'h0);
    set_row(29, 4'b0111, 0, 0, 1, 2, 1, 4'h0);
    set_row(30, 4'b1111, 0, 0, 1, 2, 1, 4'h0);
    set_row(31, 4'b0111, 0, 0, 1, 2, 1, 4'h0);
    set_row(32, 4'b1111, 0, 0, 1, 2, 1, 4'h8);
    set_row(33, 4'b1111, 1, 0, 1, 3, 1, 4'h8);
    set_row(34, 4'b1111, 1, 0, 0, 3, 1, 4'h8);
    set_row(35, 4'b1111, 1, 1, 0, 3, 1, 4'h0);
    set_row(36, 4'b1111, 1, 0, 0, 3, 1, 4'h0);
    set_row(37, 4'b1110, 0, 0, 0, 3, 1, 4'h0);
    set_row(38, 4'b0110, 0, 0, 0, 3, 1, 4'h0);
    set_row(39, 4'b0111, 0, 0, 0, 3, 1, 4'h0);
    set_row(40, 4'b1111, 0, 0, 1, 0, 1, 4'h0);
    set_row(41, 4'b0111, 0, 0, 1, 0, 1, 4'h0);
    set_row(42, 4'b1111, 1, 0, 1, 3, 1, 4'h0);
    set_row(43, 4'b1111, 1, 0, 1, 3, 1, 4'h0);
    set_row(44, 4'b1111, 1, 0, 0, 3, 1, 4'h0);
  endtask

  initial begin
    logic [N-1:0] s;
    logic [N-1:0] flip;
    fill_table();
    model_reset();

    // Reset with switch 1 held down.
    sw = 4'b0010; rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_zero("reset");
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < NV; i++) begin
      cycle(tbl[i].sw, tbl[i].rdy, tbl[i].clr);
      cmp_model($sformatf("vec%0d model", i));
`ifndef SWITCH_RELEASE_EVENTS_EN
      check($sformatf("vec%0d valid", i), 32'(ev_valid), 32'(tbl[i].ev));
      check($sformatf("vec%0d id", i),    32'(ev_id),    32'(tbl[i].id));
      check($sformatf("vec%0d press", i), 32'(ev_press), 32'(tbl[i].pr));
      check($sformatf("vec%0d ovf", i),   32'(ovf),      32'(tbl[i].ovf));
`endif
    end

    // Reset while an event is offered and two slots are pending.
    cycle(4'b0000, 0, 0);
    cycle(4'b0001, 0, 0);
    cycle(4'b0111, 0, 0);
    check("pre_reset valid", 32'(ev_valid), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    cmp_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0111, 1, 0);
      cmp_model($sformatf("post_reset%0d", i));
      check($sformatf("post_reset%0d stale", i), 32'(ev_valid), 32'd0);
    end

    // Randomized traffic with occasional resets.
    s = 4'b0111;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        cmp_zero($sformatf("rnd_reset%0d", i));
        @(negedge clk);
        rst = 1'b0;
      end
      flip = '0;
      for (int k = 0; k < N; k++) flip[k] = ($urandom_range(0, 3) == 0);
      s = s ^ flip;
      cycle(s, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      cmp_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
